dkong_sound_core: RTL and testbench
===================================

DKONG_SOUND_CORE -- requirements
Module: dkong_sound

Interface
REQ-001 SHALL have exactly one clock; reset is synchronous and active-high.
REQ-002 Ports, each as name, direction, width, meaning:
- masterclk  in  1  master clock, 61.44 MHz nominal; all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- vf2  in  1  asynchronous noise clock, ~4 kHz.
- bg_port  in  4  background tune select, active-low.
- sfx_port  in  6  sound-effect request bits, active-low.
- audio_irq  in  1  effect-start request, active-low level.
- audio_ack  out  1  one-cycle acknowledge of an accepted request.
- dac_mute  out  1  high when no sound source is active.
- dac_out  out  8  unsigned mixed audio sample, midscale 0x80.
- walk_out, jump_out, crash_out  out  1 each  discrete-effect trigger levels.
REQ-003 Internal decoded codes are bg_code = ~bg_port and sfx_code = ~sfx_port.

Function
REQ-004 SHALL derive sound_tick from a mod-10 prescaler on masterclk, asserted one cycle when the count equals 9 (6.144 MHz rate).
REQ-005 SHALL pass vf2 through a 2-flop synchronizer and detect its rising edge as noise_step.
REQ-006 SHALL hold a 15-bit LFSR, polynomial x^15+x^14+1, seeded 0x7FFF.
- Shifts once per noise_step.
- noise_bit = LFSR bit 0.
- The LFSR never reaches zero.
REQ-007 Tone generator:
- base = 1024 + 64*bg_code, in sound ticks.
- A 2-bit note step advances every 65536 sound ticks.
- half_period = base >> shift, with shift = {0,1,0,1} for steps 0..3.
- The square output toggles when the tone counter reaches half_period-1; the counter then clears.
REQ-008 When bg_code = 0:
- tone counter, note step and square are held at 0.
- Tone contribution is 0.
REQ-009 A change of bg_code SHALL restart the tone counter and note step at 0 on the next cycle.
REQ-010 walk_out, jump_out and crash_out SHALL be sfx_code[0], [1] and [2] respectively, registered one cycle.
REQ-011 Crash noise contribution:
- +32 when crash_out=1 and noise_bit=1.
- -32 when crash_out=1 and noise_bit=0.
- 0 when crash_out=0.
REQ-012 Effect engine, states IDLE and PLAY:
- In IDLE, a synchronized audio_irq=0 with sfx_code[5:3] != 0 latches eff = sfx_code[5:3], pulses audio_ack for one cycle, and enters PLAY.
- If audio_irq=0 but sfx_code[5:3] = 0: no ack, stay in IDLE.
REQ-013 PLAY behaviour:
- Effect square half-period is 512*eff sound ticks; contribution is ±24.
- Duration is 8192*eff sound ticks; then return to IDLE.
- audio_irq is ignored during PLAY.
- A new request is accepted only after audio_irq has been seen high in IDLE. One irq-low episode yields exactly one ack.
REQ-014 Tone contribution SHALL be +32 for square=1 and -32 for square=0 when bg_code != 0.
REQ-015 Mixer:
- sum = 128 + tone + noise + effect, computed at 10-bit signed width.
- Saturate to 0..255, register into dac_out.
- 1-cycle latency from source state to dac_out.
REQ-016 dac_mute SHALL be 1 exactly when bg_code = 0, crash_out = 0 and the effect state is IDLE; registered with dac_out.
REQ-017 Output values SHALL never be X or Z after the first reset cycle.

Reset
REQ-018 On rst=1 at a clock edge:
- prescaler, tone counter, note step, square and effect state clear; state = IDLE.
- LFSR = 0x7FFF; synchronizers clear.
- dac_out = 0x80, dac_mute = 1, audio_ack = 0.
- walk_out, jump_out, crash_out = 0.
REQ-019 Reset asserted mid-effect or mid-tone SHALL abort immediately with no ack and no residual output.

Verification
REQ-020 Reset, with bg_port=0xF, sfx_port=0x3F, audio_irq=1 -> dac_out=0x80, dac_mute=1 for all cycles.
REQ-021 bg_port=~4'b0100 (code 4), others inactive, reset released:
- dac_out alternates 0xA0/0x60.
- First toggle after 1280 sound ticks.
- Octave doubling every 65536 ticks.
- dac_mute=0; no X over 48000 samples.
REQ-022 sfx_port=~6'b000100 -> crash_out=1 one cycle later; dac_out in {0x60,0xA0} following noise_bit, changing only after vf2 rising edges.
REQ-023 sfx_port=~6'b001000 with audio_irq pulsed low:
- audio_ack high exactly one cycle.
- dac_out toggles 0x98/0x68 with half-period 512 ticks for 8192 ticks, then returns to 0x80 with dac_mute=1.
- Holding audio_irq low does not retrigger.
REQ-024 Tone code 15 + crash + effect all positive -> sum 216 = 0xD8, no saturation; all negative -> 0x28; reset asserted mid-PLAY -> next cycle 0x80, IDLE.

Source files
------------

// File: rtl/dkong_sound_core.sv
// dkong_sound_core
//   Sound generator for the Donkey Kong board: background tune square wave,
//   LFSR crash noise and a one-shot effect engine, mixed into an unsigned
//   8-bit DAC sample centred on 0x80.
//
// Parameters
//   PRESC_DIV  masterclk cycles per sound tick (10: 61.44 MHz -> 6.144 MHz)
//
// Ports
//   masterclk  in   master clock, all logic on its rising edge
//   rst        in   synchronous active-high reset
//   vf2        in   asynchronous ~4 kHz noise clock
//   bg_port    in   [3:0] background tune select, active-low
//   sfx_port   in   [5:0] sound-effect request bits, active-low
//   audio_irq  in   effect-start request, active-low level
//   audio_ack  out  one-cycle acknowledge of an accepted request
//   dac_mute   out  high when no sound source is active
//   dac_out    out  [7:0] mixed audio sample, midscale 0x80
//   walk_out   out  discrete walk trigger (sfx_code[0], registered)
//   jump_out   out  discrete jump trigger (sfx_code[1], registered)
//   crash_out  out  discrete crash trigger (sfx_code[2], registered)
module dkong_sound_core #(
  parameter int PRESC_DIV = 10
) (
  input  logic       masterclk,
  input  logic       rst,
  input  logic       vf2,
  input  logic [3:0] bg_port,
  input  logic [5:0] sfx_port,
  input  logic       audio_irq,
  output logic       audio_ack,
  output logic       dac_mute,
  output logic [7:0] dac_out,
  output logic       walk_out,
  output logic       jump_out,
  output logic       crash_out
);

  localparam int PW = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    PLAY = 1'b1
  } eff_state_t;

  logic [3:0] bg_code;
  logic [5:0] sfx_code;

  assign bg_code  = ~bg_port;
  assign sfx_code = ~sfx_port;

  // ---------------------------------------------------------------------
  // Sound tick prescaler
  // ---------------------------------------------------------------------
  logic [PW-1:0] presc_reg;
  logic          sound_tick;

  assign sound_tick = (presc_reg == PW'(PRESC_DIV - 1));

  always_ff @(posedge masterclk) begin
    if (rst) begin
      presc_reg <= '0;
    end else if (sound_tick) begin
      presc_reg <= '0;
    end else begin
      presc_reg <= presc_reg + 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // vf2 synchronizer, rising-edge detect and noise LFSR
  // ---------------------------------------------------------------------
  logic        vf2_meta_reg;
  logic        vf2_sync_reg;
  logic        vf2_prev_reg;
  logic        noise_step;
  logic [14:0] lfsr_reg;
  logic        noise_bit;

  assign noise_step = vf2_sync_reg & ~vf2_prev_reg;
  assign noise_bit  = lfsr_reg[0];

  always_ff @(posedge masterclk) begin
    if (rst) begin
      vf2_meta_reg <= 1'b0;
      vf2_sync_reg <= 1'b0;
      vf2_prev_reg <= 1'b0;
      lfsr_reg     <= 15'h7FFF;
    end else begin
      vf2_meta_reg <= vf2;
      vf2_sync_reg <= vf2_meta_reg;
      vf2_prev_reg <= vf2_sync_reg;
      // x^15 + x^14 + 1; a non-zero seed can never reach the all-zero state
      if (noise_step) begin
        lfsr_reg <= {lfsr_reg[13:0], lfsr_reg[14] ^ lfsr_reg[13]};
      end
    end
  end

  // ---------------------------------------------------------------------
  // Background tone generator
  // ---------------------------------------------------------------------
  logic [3:0]  bg_prev_reg;
  logic [10:0] tone_cnt_reg;
  logic [15:0] note_cnt_reg;
  logic [1:0]  note_step_reg;
  logic        square_reg;
  logic [10:0] tone_base;
  logic [10:0] half_period;

  assign tone_base   = 11'd1024 + {1'b0, bg_code, 6'd0};
  assign half_period = note_step_reg[0] ? (tone_base >> 1) : tone_base;

  always_ff @(posedge masterclk) begin
    if (rst) begin
      bg_prev_reg   <= 4'd0;
      tone_cnt_reg  <= 11'd0;
      note_cnt_reg  <= 16'd0;
      note_step_reg <= 2'd0;
      square_reg    <= 1'b0;
    end else begin
      bg_prev_reg <= bg_code;
      if (bg_code == 4'd0) begin
        tone_cnt_reg  <= 11'd0;
        note_cnt_reg  <= 16'd0;
        note_step_reg <= 2'd0;
        square_reg    <= 1'b0;
      end else if (bg_code != bg_prev_reg) begin
        tone_cnt_reg  <= 11'd0;
        note_cnt_reg  <= 16'd0;
        note_step_reg <= 2'd0;
      end else if (sound_tick) begin
        // >= so that a halved period after a note step cannot be overrun
        if (tone_cnt_reg >= half_period - 11'd1) begin
          square_reg   <= ~square_reg;
          tone_cnt_reg <= 11'd0;
        end else begin
          tone_cnt_reg <= tone_cnt_reg + 11'd1;
        end
        note_cnt_reg <= note_cnt_reg + 16'd1;
        if (note_cnt_reg == 16'hFFFF) begin
          note_step_reg <= note_step_reg + 2'd1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Discrete effect triggers
  // ---------------------------------------------------------------------
  logic walk_reg;
  logic jump_reg;
  logic crash_reg;

  always_ff @(posedge masterclk) begin
    if (rst) begin
      walk_reg  <= 1'b0;
      jump_reg  <= 1'b0;
      crash_reg <= 1'b0;
    end else begin
      walk_reg  <= sfx_code[0];
      jump_reg  <= sfx_code[1];
      crash_reg <= sfx_code[2];
    end
  end

  // ---------------------------------------------------------------------
  // Effect engine
  // ---------------------------------------------------------------------
  eff_state_t  state_reg;
  eff_state_t  state_next;
  logic        irq_meta_reg;
  logic        irq_sync_reg;
  logic        armed_reg;       // irq seen high in IDLE since last accept
  logic        audio_ack_reg;
  logic [2:0]  eff_reg;
  logic [11:0] eff_half_cnt_reg;
  logic [15:0] eff_dur_cnt_reg;
  logic        eff_sq_reg;
  logic [11:0] eff_half;
  logic [15:0] eff_dur;
  logic        accept;
  logic        play_done;

  assign eff_half  = {eff_reg, 9'd0};
  assign eff_dur   = {eff_reg, 13'd0};
  assign play_done = sound_tick && (eff_dur_cnt_reg == eff_dur - 16'd1);

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (armed_reg && !irq_sync_reg && (sfx_code[5:3] != 3'd0)) begin
          accept     = 1'b1;
          state_next = PLAY;
        end
      end
      PLAY: begin
        if (play_done) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge masterclk) begin
    if (rst) begin
      state_reg        <= IDLE;
      irq_meta_reg     <= 1'b0;
      irq_sync_reg     <= 1'b0;
      armed_reg        <= 1'b0;
      audio_ack_reg    <= 1'b0;
      eff_reg          <= 3'd0;
      eff_half_cnt_reg <= 12'd0;
      eff_dur_cnt_reg  <= 16'd0;
      eff_sq_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      audio_ack_reg <= accept;
      irq_meta_reg  <= audio_irq;
      irq_sync_reg  <= irq_meta_reg;
      // Arming only happens in IDLE, so one low episode gives one ack
      if (state_reg == IDLE) begin
        armed_reg <= accept ? 1'b0 : (armed_reg | irq_sync_reg);
      end
      if (accept) begin
        eff_reg          <= sfx_code[5:3];
        eff_half_cnt_reg <= 12'd0;
        eff_dur_cnt_reg  <= 16'd0;
        eff_sq_reg       <= 1'b0;
      end else if ((state_reg == PLAY) && sound_tick) begin
        if (play_done) begin
          eff_half_cnt_reg <= 12'd0;
          eff_dur_cnt_reg  <= 16'd0;
          eff_sq_reg       <= 1'b0;
        end else begin
          eff_dur_cnt_reg <= eff_dur_cnt_reg + 16'd1;
          if (eff_half_cnt_reg == eff_half - 12'd1) begin
            eff_sq_reg       <= ~eff_sq_reg;
            eff_half_cnt_reg <= 12'd0;
          end else begin
            eff_half_cnt_reg <= eff_half_cnt_reg + 12'd1;
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Mixer
  // ---------------------------------------------------------------------
  logic signed [9:0] tone_c;
  logic signed [9:0] noise_c;
  logic signed [9:0] eff_c;
  logic signed [9:0] mix_sum;
  logic [7:0]        dac_reg;
  logic              mute_reg;

  always_comb begin
    tone_c  = 10'sd0;
    noise_c = 10'sd0;
    eff_c   = 10'sd0;
    if (bg_code != 4'd0) begin
      tone_c = square_reg ? 10'sd32 : -10'sd32;
    end
    if (crash_reg) begin
      noise_c = noise_bit ? 10'sd32 : -10'sd32;
    end
    if (state_reg == PLAY) begin
      eff_c = eff_sq_reg ? 10'sd24 : -10'sd24;
    end
    mix_sum = 10'sd128 + tone_c + noise_c + eff_c;
  end

  always_ff @(posedge masterclk) begin
    if (rst) begin
      dac_reg  <= 8'h80;
      mute_reg <= 1'b1;
    end else begin
      if (mix_sum < 10'sd0) begin
        dac_reg <= 8'h00;
      end else if (mix_sum > 10'sd255) begin
        dac_reg <= 8'hFF;
      end else begin
        dac_reg <= mix_sum[7:0];
      end
      mute_reg <= (bg_code == 4'd0) && !crash_reg && (state_reg == IDLE);
    end
  end

  assign audio_ack = audio_ack_reg;
  assign dac_mute  = mute_reg;
  assign dac_out   = dac_reg;
  assign walk_out  = walk_reg;
  assign jump_out  = jump_reg;
  assign crash_out = crash_reg;

endmodule

// File: tb/tb_dkong_sound_core.sv
// Self-checking bench for dkong_sound_core: table of steady-state vectors
// followed by hand-written sequences for noise, tone, effect and mixing.
module tb_dkong_sound_core;

  localparam int DIV = 4;  // shortened sound tick so full effects fit the run

  logic       masterclk = 1'b0;
  logic       rst = 1'b1;
  logic       vf2 = 1'b0;
  logic [3:0] bg_port = 4'hF;
  logic [5:0] sfx_port = 6'h3F;
  logic       audio_irq = 1'b1;
  logic       audio_ack;
  logic       dac_mute;
  logic [7:0] dac_out;
  logic       walk_out;
  logic       jump_out;
  logic       crash_out;

  dkong_sound_core #(.PRESC_DIV(DIV)) dut (
    .masterclk (masterclk),
    .rst       (rst),
    .vf2       (vf2),
    .bg_port   (bg_port),
    .sfx_port  (sfx_port),
    .audio_irq (audio_irq),
    .audio_ack (audio_ack),
    .dac_mute  (dac_mute),
    .dac_out   (dac_out),
    .walk_out  (walk_out),
    .jump_out  (jump_out),
    .crash_out (crash_out)
  );

  always #5 masterclk = ~masterclk;

  typedef struct {
    logic [3:0] bg;    // bg_code
    logic [5:0] sfx;   // sfx_code
    logic [2:0] disc;  // {crash, jump, walk}
    logic [7:0] dac;
    logic       mute;
  } vec_t;

  vec_t vecs[10];

  int n_checks = 0;
  int n_pass = 0;

  int          bad;
  int          got;
  int          ack_cnt;
  int          done;
  int          nruns;
  int          cur_len;
  int          bad_val;
  int          bad_run;
  int          bad_mute;
  int          elapsed;
  int          exp_len;
  logic [7:0]  cur_val;
  logic [7:0]  exp_val;
  logic [14:0] lfsr_m;
  logic [7:0]  prev_exp;
  int          run_len[32];
  logic [7:0]  run_val[32];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge masterclk);
    #1;
  endtask

  task automatic do_reset(input logic [3:0] bg, input logic [5:0] sfx, input logic irq);
    rst = 1'b1;
    bg_port = bg;
    sfx_port = sfx;
    audio_irq = irq;
    vf2 = 1'b0;
    step(3);
    rst = 1'b0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---------------- reset state ----------------
    step(3);
    check("rst_dac", int'(dac_out), 8'h80);
    check("rst_mute", int'(dac_mute), 1);
    check("rst_ack", int'(audio_ack), 0);
    check("rst_disc", int'({walk_out, jump_out, crash_out}), 0);
    rst = 1'b0;
    bad = 0;
    for (int c = 0; c < 40; c++) begin
      step(1);
      if ($isunknown({dac_out, dac_mute}) || dac_out != 8'h80 || dac_mute != 1'b1) bad++;
    end
    check("idle_quiet", bad, 0);
    $display("reset: dac=0x%0h mute=%0b", dac_out, dac_mute);

    // ---------------- steady-state vectors ----------------
    vecs[0] = '{4'd0,  6'b000000, 3'b000, 8'h80, 1'b1};
    vecs[1] = '{4'd0,  6'b000001, 3'b001, 8'h80, 1'b1};
    vecs[2] = '{4'd0,  6'b000010, 3'b010, 8'h80, 1'b1};
    vecs[3] = '{4'd0,  6'b000100, 3'b100, 8'hA0, 1'b0};
    vecs[4] = '{4'd4,  6'b000000, 3'b000, 8'h60, 1'b0};
    vecs[5] = '{4'd4,  6'b000100, 3'b100, 8'h80, 1'b0};
    vecs[6] = '{4'd15, 6'b000111, 3'b111, 8'h80, 1'b0};
    vecs[7] = '{4'd0,  6'b111000, 3'b000, 8'h80, 1'b1};
    vecs[8] = '{4'd1,  6'b000011, 3'b011, 8'h60, 1'b0};
    vecs[9] = '{4'd8,  6'b000101, 3'b101, 8'h80, 1'b0};
    do_reset(4'hF, 6'h3F, 1'b1);
    for (int i = 0; i < 10; i++) begin
      bg_port = ~vecs[i].bg;
      sfx_port = ~vecs[i].sfx;
      step(3);
      check("vec_disc", int'({crash_out, jump_out, walk_out}), int'(vecs[i].disc));
      check("vec_dac", int'(dac_out), int'(vecs[i].dac));
      check("vec_mute", int'(dac_mute), int'(vecs[i].mute));
      $display("vec %0d: bg=%0d sfx=%b disc=%b dac=0x%0h mute=%0b",
               i, vecs[i].bg, vecs[i].sfx, {crash_out, jump_out, walk_out}, dac_out, dac_mute);
    end

    // ---------------- crash noise follows LFSR ----------------
    do_reset(4'hF, ~6'b000100, 1'b1);
    step(1);
    check("crash_latency", int'(crash_out), 1);
    step(1);
    check("crash_seed", int'(dac_out), 8'hA0);
    lfsr_m = 15'h7FFF;
    prev_exp = 8'hA0;
    for (int i = 0; i < 20; i++) begin
      vf2 = 1'b1;
      step(2);
      check("noise_hold", int'(dac_out), int'(prev_exp));
      step(2);
      lfsr_m = {lfsr_m[13:0], lfsr_m[14] ^ lfsr_m[13]};
      prev_exp = lfsr_m[0] ? 8'hA0 : 8'h60;
      check("noise_step", int'(dac_out), int'(prev_exp));
      $display("vf2 edge %0d: lfsr=0x%0h dac=0x%0h", i, lfsr_m, dac_out);
      vf2 = 1'b0;
      step(4);
    end

    // ---------------- tone code 4 ----------------
    do_reset(~4'd4, 6'h3F, 1'b1);
    bad = 0;
    for (int c = 1; c <= 2560 * DIV + 1; c++) begin
      step(1);
      if (c == 1) begin
        check("tone_start", int'(dac_out), 8'h60);
        check("tone_mute", int'(dac_mute), 0);
      end
      if (c == 1280 * DIV) check("tone_pre1", int'(dac_out), 8'h60);
      if (c == 1280 * DIV + 1) check("tone_tog1", int'(dac_out), 8'hA0);
      if (c == 2560 * DIV) check("tone_pre2", int'(dac_out), 8'hA0);
      if (c == 2560 * DIV + 1) check("tone_tog2", int'(dac_out), 8'h60);
      if ($isunknown({dac_out, dac_mute}) || dac_mute != 1'b0 ||
          (dac_out != 8'h60 && dac_out != 8'hA0)) bad++;
    end
    check("tone_values", bad, 0);
    $display("tone: two toggles observed, dac=0x%0h", dac_out);

    // ---------------- effect 1 ----------------
    do_reset(4'hF, ~6'b001000, 1'b1);
    step(5);
    audio_irq = 1'b0;  // held low for the whole effect and beyond
    got = 0;
    for (int c = 0; c < 20 && got == 0; c++) begin
      step(1);
      if (audio_ack) got = 1;
    end
    check("eff_ack", got, 1);
    cur_val = 8'h68;
    cur_len = 0;
    nruns = 0;
    ack_cnt = 1;
    done = 0;
    bad_val = 0;
    bad_mute = 0;
    for (int c = 0; c < 8192 * DIV + 64 && done == 0; c++) begin
      step(1);
      if (audio_ack) ack_cnt++;
      if (dac_out == 8'h80) begin
        done = 1;
        if (nruns < 32) begin
          run_val[nruns] = cur_val;
          run_len[nruns] = cur_len;
        end
        nruns++;
      end else begin
        if (dac_mute) bad_mute++;
        if (dac_out == cur_val) begin
          cur_len++;
        end else begin
          if (dac_out != 8'h68 && dac_out != 8'h98) bad_val++;
          if (nruns < 32) begin
            run_val[nruns] = cur_val;
            run_len[nruns] = cur_len;
          end
          nruns++;
          cur_val = dac_out;
          cur_len = 1;
        end
      end
    end
    check("eff_done", done, 1);
    check("eff_end_mute", int'(dac_mute), 1);
    check("eff_runs", nruns, 16);
    check("eff_ack_once", ack_cnt, 1);
    check("eff_values", bad_val, 0);
    check("eff_play_mute", bad_mute, 0);
    check("eff_first_half",
          int'(run_len[0] >= 511 * DIV + 1 && run_len[0] <= 512 * DIV), 1);
    bad_run = 0;
    for (int i = 0; i < nruns && i < 32; i++) begin
      exp_val = (i % 2 == 0) ? 8'h68 : 8'h98;
      exp_len = 512 * DIV;
      if (run_val[i] != exp_val) bad_run++;
      if (i > 0 && run_len[i] != exp_len) bad_run++;
      $display("eff run %0d: dac=0x%0h cycles=%0d", i, run_val[i], run_len[i]);
    end
    check("eff_run_shape", bad_run, 0);
    ack_cnt = 0;
    bad = 0;
    for (int c = 0; c < 50; c++) begin
      step(1);
      if (audio_ack) ack_cnt++;
      if (dac_out != 8'h80) bad++;
    end
    check("eff_no_retrigger", ack_cnt, 0);
    check("eff_idle_dac", bad, 0);
    audio_irq = 1'b1;
    step(5);
    audio_irq = 1'b0;
    got = 0;
    for (int c = 0; c < 20 && got == 0; c++) begin
      step(1);
      if (audio_ack) got = 1;
    end
    check("eff_rearm_ack", got, 1);
    $display("effect: runs=%0d rearm_ack=%0d", nruns, got);

    // ---------------- mixing extremes and reset mid-PLAY ----------------
    do_reset(~4'd15, ~6'b100100, 1'b1);
    elapsed = 0;
    step(4);
    elapsed += 4;
    audio_irq = 1'b0;
    got = 0;
    for (int c = 0; c < 20 && got == 0; c++) begin
      step(1);
      elapsed++;
      if (audio_ack) got = 1;
    end
    check("mix_ack", got, 1);
    step(2500 * DIV - elapsed);
    check("mix_all_pos", int'(dac_out), 8'hD8);
    check("mix_mute", int'(dac_mute), 0);
    step(1900 * DIV);
    vf2 = 1'b1;
    step(4);
    vf2 = 1'b0;
    step(4);
    check("mix_all_neg", int'(dac_out), 8'h28);
    $display("mix: neg dac=0x%0h", dac_out);
    rst = 1'b1;
    step(1);
    check("midplay_rst_dac", int'(dac_out), 8'h80);
    check("midplay_rst_mute", int'(dac_mute), 1);
    check("midplay_rst_ack", int'(audio_ack), 0);
    check("midplay_rst_crash", int'(crash_out), 0);
    rst = 1'b0;
    ack_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      step(1);
      if (audio_ack) ack_cnt++;
    end
    check("post_rst_no_ack", ack_cnt, 0);
    check("post_rst_idle_dac", int'(dac_out), 8'h80);
    $display("reset mid-PLAY: dac=0x%0h acks=%0d", dac_out, ack_cnt);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
